// File: rtl/ascii_screen_dump_pkg.sv
// Shared definitions for the text-screen dump path: FSM encoding, the bytes
// it emits, printable range and the text-buffer geometry that the receive
// side also uses.
package ascii_screen_dump_pkg;

  // Text buffer geometry (80x60 cells, row-major addressing)
  localparam int SCREEN_MAXX   = 79;
  localparam int SCREEN_MAXY   = 59;
  localparam int SCREEN_ADDR_W = 13;

  // Bytes emitted around the cell data
  localparam logic [7:0] CH_ESC      = 8'h1b;
  localparam logic [7:0] CH_LBRACKET = 8'h5b;
  localparam logic [7:0] CH_H        = 8'h48;
  localparam logic [7:0] CH_CR       = 8'h0d;
  localparam logic [7:0] CH_LF       = 8'h0a;
  localparam logic [7:0] CH_SPACE    = 8'h20;

  // Printable ASCII range; anything outside is sent as a space
  localparam logic [7:0] PRINT_MIN = 8'd32;
  localparam logic [7:0] PRINT_MAX = 8'd126;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_READ,
    ST_WAIT,
    ST_SEND,
    ST_EOL_CR,
    ST_EOL_LF,
    ST_FINISH
  } dump_state_t;

  // Replace control codes and DEL/high bytes so the terminal only sees text
  function automatic logic [7:0] sanitize_char(input logic [7:0] c);
    if (c < PRINT_MIN || c > PRINT_MAX) begin
      return CH_SPACE;
    end
    return c;
  endfunction

  // Cursor-home sequence ESC [ H, indexed 0..2
  function automatic logic [7:0] prefix_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return CH_ESC;
      2'd1:    return CH_LBRACKET;
      default: return CH_H;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. A byte is accepted on tx_start while tx_busy is low.
// tx_busy drops at the start of the last stop-bit cycle, so a byte offered
// in that cycle begins exactly as the stop bit ends; the stop bit is never
// shortened. Requires CLKS_PER_BIT >= 2.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST    = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_RELEASE = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [3:0]        STOP_BIT     = 4'd9;

  logic              busy_reg,  busy_next;
  logic              tx_reg,    tx_next;
  logic [BAUD_W-1:0] baud_reg,  baud_next;
  logic [3:0]        bit_reg,   bit_next;
  logic [8:0]        shift_reg, shift_next;

  // Baud/bit sequencing: start bit on accept, then data LSB first, then stop
  always_comb begin
    busy_next  = busy_reg;
    tx_next    = tx_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    if (tx_start && !busy_reg) begin
      busy_next  = 1'b1;
      tx_next    = 1'b0;
      baud_next  = '0;
      bit_next   = 4'd0;
      shift_next = {1'b1, tx_data};
    end else if (busy_reg) begin
      if (baud_reg == BAUD_LAST) begin
        baud_next  = '0;
        bit_next   = bit_reg + 4'd1;
        tx_next    = shift_reg[0];
        shift_next = {1'b1, shift_reg[8:1]};
      end else begin
        baud_next = baud_reg + BAUD_W'(1);
      end
      if (bit_reg == STOP_BIT && baud_reg == BAUD_RELEASE) begin
        busy_next = 1'b0;
      end
    end
  end

  // State registers; reset parks the line high at once
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_reg  <= 1'b0;
      tx_reg    <= 1'b1;
      baud_reg  <= '0;
      bit_reg   <= 4'd0;
      shift_reg <= '0;
    end else begin
      busy_reg  <= busy_next;
      tx_reg    <= tx_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  assign tx_busy = busy_reg;
  assign tx      = tx_reg;

endmodule

// File: rtl/ascii_screen_dump.sv
// Replays the VGA text buffer over UART so a host terminal can re-sync:
// ESC [ H, then every cell row-major with CR LF after each row.
module ascii_screen_dump
  import ascii_screen_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAXX         = SCREEN_MAXX,
  parameter int MAXY         = SCREEN_MAXY,
  parameter int ADDR_W       = SCREEN_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [7:0]        rd_data,
  output logic              tx
);

  localparam int COL_W = (MAXX > 0) ? $clog2(MAXX + 1) : 1;
  localparam int ROW_W = (MAXY > 0) ? $clog2(MAXY + 1) : 1;
  localparam logic [COL_W-1:0] LAST_COL    = COL_W'(MAXX);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(MAXY);
  localparam logic [1:0]       LAST_PREFIX = 2'd2;

  dump_state_t       state_reg,    state_next;
  logic [1:0]        idx_reg,      idx_next;
  logic [COL_W-1:0]  col_reg,      col_next;
  logic [ROW_W-1:0]  row_reg,      row_next;
  // Running cell address; equals row*(MAXX+1)+col because cells go row-major
  logic [ADDR_W-1:0] addr_reg,     addr_next;
  logic [7:0]        char_reg,     char_next;
  // Set once the current byte has been handed to the transmitter
  logic              launched_reg, launched_next;
  logic              abort_reg,    abort_next;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       byte_state;
  logic       byte_done;
  logic       abort_pend;
  logic [7:0] cur_byte;

  assign busy    = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);
  assign done    = (state_reg == ST_FINISH);
  assign rd_en   = (state_reg == ST_READ);
  assign rd_addr = addr_reg;

  assign byte_state = (state_reg == ST_PREFIX) || (state_reg == ST_SEND) ||
                      (state_reg == ST_EOL_CR) || (state_reg == ST_EOL_LF);
  // tx_busy is already high the cycle after launch, so low here means finished
  assign byte_done  = byte_state && launched_reg && !tx_busy;
  assign abort_pend = abort_reg || abort;

  // Next-state logic, byte launch handshake and abort latching
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    col_next      = col_reg;
    row_next      = row_reg;
    addr_next     = addr_reg;
    char_next     = char_reg;
    launched_next = launched_reg;
    abort_next    = abort_reg;
    tx_start      = 1'b0;
    tx_data       = 8'h00;

    case (state_reg)
      ST_PREFIX: cur_byte = prefix_byte(idx_reg);
      ST_SEND:   cur_byte = char_reg;
      ST_EOL_CR: cur_byte = CH_CR;
      ST_EOL_LF: cur_byte = CH_LF;
      default:   cur_byte = CH_SPACE;
    endcase

    if (abort && busy) begin
      abort_next = 1'b1;
    end

    if (byte_state && !launched_reg && !tx_busy) begin
      tx_start      = 1'b1;
      tx_data       = cur_byte;
      launched_next = 1'b1;
    end
    if (byte_done) begin
      launched_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        // A coincident abort is dropped: abort_next is cleared here
        if (start) begin
          state_next    = ST_PREFIX;
          idx_next      = 2'd0;
          col_next      = '0;
          row_next      = '0;
          addr_next     = '0;
          launched_next = 1'b0;
          abort_next    = 1'b0;
        end
      end
      ST_PREFIX: begin
        if (byte_done) begin
          if (abort_pend) begin
            state_next = ST_FINISH;
          end else if (idx_reg == LAST_PREFIX) begin
            state_next = ST_READ;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
      ST_READ: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        char_next  = sanitize_char(rd_data);
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (byte_done) begin
          addr_next = addr_reg + ADDR_W'(1);
          if (abort_pend) begin
            state_next = ST_FINISH;
          end else if (col_reg == LAST_COL) begin
            col_next   = '0;
            state_next = ST_EOL_CR;
          end else begin
            col_next   = col_reg + COL_W'(1);
            state_next = ST_READ;
          end
        end
      end
      ST_EOL_CR: begin
        if (byte_done) begin
          state_next = abort_pend ? ST_FINISH : ST_EOL_LF;
        end
      end
      ST_EOL_LF: begin
        if (byte_done) begin
          if (abort_pend || row_reg == LAST_ROW) begin
            state_next = ST_FINISH;
          end else begin
            row_next   = row_reg + ROW_W'(1);
            state_next = ST_READ;
          end
        end
      end
      ST_FINISH: begin
        abort_next = 1'b0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= 2'd0;
      col_reg      <= '0;
      row_reg      <= '0;
      addr_reg     <= '0;
      char_reg     <= 8'h00;
      launched_reg <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      addr_reg     <= addr_next;
      char_reg     <= char_next;
      launched_reg <= launched_next;
      abort_reg    <= abort_next;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk     (clk),
    .rstn    (rstn),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .tx      (tx)
  );

endmodule
